// File: rtl/toy_bus_pkg.sv
// ToyBus field widths and packed request/ack payload layouts shared by the
// pipeline slice and its skid buffers.
package toy_bus_pkg;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int STRB_W = DATA_W / 8;
   localparam int ID_W   = 4;

   // Request beat, MSB first: {addr, strb, data, opcode, src_id, tgt_id}
   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [STRB_W-1:0] strb;
      logic [DATA_W-1:0] data;
      logic              opcode;
      logic [ID_W-1:0]   src_id;
      logic [ID_W-1:0]   tgt_id;
   } req_t;

   // Ack beat, MSB first: {opcode, data, src_id, tgt_id}
   typedef struct packed {
      logic              opcode;
      logic [DATA_W-1:0] data;
      logic [ID_W-1:0]   src_id;
      logic [ID_W-1:0]   tgt_id;
   } ack_t;

   localparam int REQ_W = $bits(req_t);
   localparam int ACK_W = $bits(ack_t);

endpackage

// File: rtl/toy_bus_skid2.sv
// Generic 2-entry vld/rdy skid buffer. Entry 0 is always the head. Both
// handshake outputs and the payload come straight from flops, so no input
// reaches an output combinationally.
module toy_bus_skid2 #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_vld,
   output logic         in_rdy,
   input  logic [W-1:0] in_data,
   output logic         out_vld,
   input  logic         out_rdy,
   output logic [W-1:0] out_data
);

   logic [1:0]   occ_r;
   logic [1:0]   occ_nxt_s;
   logic         in_rdy_r;
   logic         out_vld_r;
   logic         push_s;
   logic         pop_s;
   logic [W-1:0] ent0_r;
   logic [W-1:0] ent1_r;

   // Decode handshakes and compute next occupancy.
   always_comb begin
      push_s    = in_vld & in_rdy_r;
      pop_s     = out_vld_r & out_rdy;
      occ_nxt_s = occ_r;
      if (push_s && !pop_s) begin
         occ_nxt_s = occ_r + 2'd1;
      end else if (!push_s && pop_s) begin
         occ_nxt_s = occ_r - 2'd1;
      end else begin
         occ_nxt_s = occ_r;
      end
   end

   // Occupancy and registered handshake flags, derived from next occupancy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         occ_r     <= 2'd0;
         in_rdy_r  <= 1'b1;
         out_vld_r <= 1'b0;
      end else begin
         occ_r     <= occ_nxt_s;
         in_rdy_r  <= (occ_nxt_s != 2'd2);
         out_vld_r <= (occ_nxt_s != 2'd0);
      end
   end

   // Payload storage; invalid entries are masked by occupancy, so no reset.
   always_ff @(posedge clk) begin
      case (occ_r)
         2'd0: begin
            if (push_s) ent0_r <= in_data;
         end
         2'd1: begin
            if (push_s && pop_s) ent0_r <= in_data;
            else if (push_s)     ent1_r <= in_data;
         end
         2'd2: begin
            if (pop_s) ent0_r <= ent1_r;
         end
         default: begin
            ent0_r <= ent0_r;
         end
      endcase
   end

   assign in_rdy   = in_rdy_r;
   assign out_vld  = out_vld_r;
   assign out_data = ent0_r;

endmodule

// File: rtl/toy_bus_dslice_req_ack.sv
// Registered ToyBus req/ack pipeline slice placed below a 2-channel arbiter.
// Skid buffers on both directions, plus an outstanding-request limiter that
// only ever throttles the request side; acks always flow.
module toy_bus_dslice_req_ack
   import toy_bus_pkg::*;
#(
   parameter  int MAX_OUTST = 4,
   localparam int CNT_W     = $clog2(MAX_OUTST + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in0_req_vld,
   output logic              in0_req_rdy,
   input  logic [ADDR_W-1:0] in0_req_addr,
   input  logic [STRB_W-1:0] in0_req_strb,
   input  logic [DATA_W-1:0] in0_req_data,
   input  logic              in0_req_opcode,
   input  logic [ID_W-1:0]   in0_req_src_id,
   input  logic [ID_W-1:0]   in0_req_tgt_id,
   output logic              in0_ack_vld,
   input  logic              in0_ack_rdy,
   output logic              in0_ack_opcode,
   output logic [DATA_W-1:0] in0_ack_data,
   output logic [ID_W-1:0]   in0_ack_src_id,
   output logic [ID_W-1:0]   in0_ack_tgt_id,
   output logic              out0_req_vld,
   input  logic              out0_req_rdy,
   output logic [ADDR_W-1:0] out0_req_addr,
   output logic [STRB_W-1:0] out0_req_strb,
   output logic [DATA_W-1:0] out0_req_data,
   output logic              out0_req_opcode,
   output logic [ID_W-1:0]   out0_req_src_id,
   output logic [ID_W-1:0]   out0_req_tgt_id,
   input  logic              out0_ack_vld,
   output logic              out0_ack_rdy,
   input  logic              out0_ack_opcode,
   input  logic [DATA_W-1:0] out0_ack_data,
   input  logic [ID_W-1:0]   out0_ack_src_id,
   input  logic [ID_W-1:0]   out0_ack_tgt_id,
   output logic [CNT_W-1:0]  outst_cnt,
   output logic              outst_err
);

   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTST);

   req_t             req_in_s;
   req_t             req_out_s;
   ack_t             ack_in_s;
   ack_t             ack_out_s;
   logic             req_buf_rdy_s;
   logic             ack_vld_s;
   logic             inc_s;
   logic             dec_s;
   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_nxt_s;
   logic             at_max_r;
   logic             err_r;
   logic             err_nxt_s;

   assign req_in_s = {in0_req_addr, in0_req_strb, in0_req_data,
                      in0_req_opcode, in0_req_src_id, in0_req_tgt_id};
   assign ack_in_s = {out0_ack_opcode, out0_ack_data, out0_ack_src_id, out0_ack_tgt_id};

   // Request slice; upstream valid is masked while the limit is reached.
   toy_bus_skid2 #(.W(REQ_W)) u_req_slice (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_vld   (in0_req_vld & ~at_max_r),
      .in_rdy   (req_buf_rdy_s),
      .in_data  (req_in_s),
      .out_vld  (out0_req_vld),
      .out_rdy  (out0_req_rdy),
      .out_data (req_out_s)
   );

   toy_bus_skid2 #(.W(ACK_W)) u_ack_slice (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_vld   (out0_ack_vld),
      .in_rdy   (out0_ack_rdy),
      .in_data  (ack_in_s),
      .out_vld  (ack_vld_s),
      .out_rdy  (in0_ack_rdy),
      .out_data (ack_out_s)
   );

   // Both terms are flops, so the ready stays free of input paths.
   assign in0_req_rdy = req_buf_rdy_s & ~at_max_r;

   // Outstanding count update: +1 on accepted req, -1 on delivered ack,
   // saturating at zero and flagging an ack that had nothing to retire.
   always_comb begin
      inc_s     = in0_req_vld & in0_req_rdy;
      dec_s     = ack_vld_s & in0_ack_rdy;
      cnt_nxt_s = cnt_r;
      err_nxt_s = err_r;
      if (inc_s && !dec_s) begin
         cnt_nxt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else if (!inc_s && dec_s && (cnt_r != {CNT_W{1'b0}})) begin
         cnt_nxt_s = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         cnt_nxt_s = cnt_r;
      end
      if (dec_s && (cnt_r == {CNT_W{1'b0}})) begin
         err_nxt_s = 1'b1;
      end else begin
         err_nxt_s = err_r;
      end
   end

   // Counter, limit flag and sticky error register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r    <= {CNT_W{1'b0}};
         at_max_r <= 1'b0;
         err_r    <= 1'b0;
      end else begin
         cnt_r    <= cnt_nxt_s;
         at_max_r <= (cnt_nxt_s == MAX_CNT);
         err_r    <= err_nxt_s;
      end
   end

   assign in0_ack_vld     = ack_vld_s;
   assign in0_ack_opcode  = ack_out_s.opcode;
   assign in0_ack_data    = ack_out_s.data;
   assign in0_ack_src_id  = ack_out_s.src_id;
   assign in0_ack_tgt_id  = ack_out_s.tgt_id;
   assign out0_req_addr   = req_out_s.addr;
   assign out0_req_strb   = req_out_s.strb;
   assign out0_req_data   = req_out_s.data;
   assign out0_req_opcode = req_out_s.opcode;
   assign out0_req_src_id = req_out_s.src_id;
   assign out0_req_tgt_id = req_out_s.tgt_id;
   assign outst_cnt       = cnt_r;
   assign outst_err       = err_r;

endmodule

// File: tb/tb_toy_bus_dslice_req_ack.sv
// Self-checking bench for toy_bus_dslice_req_ack: directed table, back-to-back
// streaming, and random traffic against a queue-based reference model.
module tb_toy_bus_dslice_req_ack;
   import toy_bus_pkg::*;

   localparam int MAXO = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic in0_req_vld, in0_req_rdy, in0_ack_vld, in0_ack_rdy;
   logic out0_req_vld, out0_req_rdy, out0_ack_vld, out0_ack_rdy;
   req_t req_in;
   ack_t ack_in;
   logic [ADDR_W-1:0] o_addr;
   logic [STRB_W-1:0] o_strb;
   logic [DATA_W-1:0] o_data, a_data;
   logic o_opc, a_opc;
   logic [ID_W-1:0] o_src, o_tgt, a_src, a_tgt;
   logic [2:0] outst_cnt;
   logic outst_err;
   req_t req_out;
   ack_t ack_out;
   assign req_out = {o_addr, o_strb, o_data, o_opc, o_src, o_tgt};
   assign ack_out = {a_opc, a_data, a_src, a_tgt};

   toy_bus_dslice_req_ack #(.MAX_OUTST(MAXO)) dut (
      .clk(clk), .rst_n(rst_n),
      .in0_req_vld(in0_req_vld), .in0_req_rdy(in0_req_rdy),
      .in0_req_addr(req_in.addr), .in0_req_strb(req_in.strb), .in0_req_data(req_in.data),
      .in0_req_opcode(req_in.opcode), .in0_req_src_id(req_in.src_id), .in0_req_tgt_id(req_in.tgt_id),
      .in0_ack_vld(in0_ack_vld), .in0_ack_rdy(in0_ack_rdy),
      .in0_ack_opcode(a_opc), .in0_ack_data(a_data), .in0_ack_src_id(a_src), .in0_ack_tgt_id(a_tgt),
      .out0_req_vld(out0_req_vld), .out0_req_rdy(out0_req_rdy),
      .out0_req_addr(o_addr), .out0_req_strb(o_strb), .out0_req_data(o_data),
      .out0_req_opcode(o_opc), .out0_req_src_id(o_src), .out0_req_tgt_id(o_tgt),
      .out0_ack_vld(out0_ack_vld), .out0_ack_rdy(out0_ack_rdy),
      .out0_ack_opcode(ack_in.opcode), .out0_ack_data(ack_in.data),
      .out0_ack_src_id(ack_in.src_id), .out0_ack_tgt_id(ack_in.tgt_id),
      .outst_cnt(outst_cnt), .outst_err(outst_err)
   );

   int vectors = 0;
   int miscompares = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      in0_req_vld  = 1'b0;
      out0_req_rdy = 1'b0;
      out0_ack_vld = 1'b0;
      in0_ack_rdy  = 1'b0;
      req_in       = '0;
      ack_in       = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
   endtask

   // Directed table: inputs for one cycle, outputs expected after the edge.
   typedef struct {
      logic rv, tr, av, ar;
      logic e_irdy, e_ovld, e_avld, e_oardy;
      int   e_cnt;
      logic e_err;
      int   e_src;   // row (1-based) whose address is at the req head, 0 = none
   } vec_t;
   vec_t tbl[$];

   function automatic vec_t mk(logic rv, logic tr, logic av, logic ar, logic irdy, logic ovld,
                               logic avld, logic oardy, int cnt, logic err, int src);
      vec_t v;
      v.rv = rv; v.tr = tr; v.av = av; v.ar = ar;
      v.e_irdy = irdy; v.e_ovld = ovld; v.e_avld = avld; v.e_oardy = oardy;
      v.e_cnt = cnt; v.e_err = err; v.e_src = src;
      return v;
   endfunction

   // Reference model: slices are plain FIFOs of depth 2.
   req_t m_rq[$];
   ack_t m_aq[$];
   int   m_cnt;
   bit   m_err;
   int   tgt_pend;

   task automatic model_cycle(input bit fill);
      bit m_irdy, push_r, pop_r, push_a, pop_a;
      in0_req_vld  = fill ? 1'b1 : 1'($urandom_range(0, 1));
      out0_req_rdy = fill ? 1'b0 : 1'($urandom_range(0, 3) != 0);
      in0_ack_rdy  = fill ? 1'b1 : 1'($urandom_range(0, 3) != 0);
      out0_ack_vld = (tgt_pend > 0) && ($urandom_range(0, 1) == 1);
      req_in = REQ_W'({$urandom(), $urandom(), $urandom()});
      ack_in = ACK_W'({$urandom(), $urandom()});
      m_irdy = (m_rq.size() < 2) && (m_cnt < MAXO);
      push_r = in0_req_vld && m_irdy;
      pop_r  = (m_rq.size() > 0) && out0_req_rdy;
      push_a = out0_ack_vld && (m_aq.size() < 2);
      pop_a  = (m_aq.size() > 0) && in0_ack_rdy;
      if (pop_r) begin void'(m_rq.pop_front()); tgt_pend++; end
      if (push_r) m_rq.push_back(req_in);
      if (pop_a) void'(m_aq.pop_front());
      if (push_a) begin m_aq.push_back(ack_in); tgt_pend--; end
      if (pop_a && m_cnt == 0) m_err = 1'b1;
      if (push_r && !pop_a) m_cnt++;
      else if (!push_r && pop_a && m_cnt > 0) m_cnt--;
      tick();
      chk("rnd_irdy", in0_req_rdy, (m_rq.size() < 2) && (m_cnt < MAXO));
      chk("rnd_ovld", out0_req_vld, m_rq.size() > 0);
      if (m_rq.size() > 0) chk("rnd_req", req_out, m_rq[0]);
      chk("rnd_oardy", out0_ack_rdy, m_aq.size() < 2);
      chk("rnd_avld", in0_ack_vld, m_aq.size() > 0);
      if (m_aq.size() > 0) chk("rnd_ack", ack_out, m_aq[0]);
      chk("rnd_cnt", outst_cnt, m_cnt);
      chk("rnd_err", outst_err, m_err);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      req_t pay[8];
      ack_t exp_ack[$];
      int   acks_seen;
      bit   filled;

      // Reset state
      do_reset();
      chk("rst_irdy", in0_req_rdy, 1'b1);
      chk("rst_oardy", out0_ack_rdy, 1'b1);
      chk("rst_ovld", out0_req_vld, 1'b0);
      chk("rst_avld", in0_ack_vld, 1'b0);
      chk("rst_cnt", outst_cnt, 0);
      chk("rst_err", outst_err, 1'b0);

      // Directed: skid fill/drain, outstanding limit, ack with count 0
      //            rv tr av ar | irdy ovld avld oardy cnt err src
      tbl.push_back(mk(1, 0, 0, 0, 1, 1, 0, 1, 1, 0, 1));
      tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 1, 2, 0, 1));
      tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 1, 2, 0, 1));
      tbl.push_back(mk(0, 1, 0, 0, 1, 1, 0, 1, 2, 0, 2));
      tbl.push_back(mk(0, 1, 0, 0, 1, 0, 0, 1, 2, 0, 0));
      tbl.push_back(mk(1, 1, 0, 0, 1, 1, 0, 1, 3, 0, 6));
      tbl.push_back(mk(1, 1, 0, 0, 0, 1, 0, 1, 4, 0, 7));
      tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 1, 4, 0, 0));
      tbl.push_back(mk(0, 0, 1, 0, 0, 0, 1, 1, 4, 0, 0));
      tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 1, 3, 0, 0));
      tbl.push_back(mk(0, 0, 1, 0, 1, 0, 1, 1, 3, 0, 0));
      tbl.push_back(mk(1, 1, 0, 1, 1, 1, 0, 1, 3, 0, 12));
      tbl.push_back(mk(0, 1, 1, 0, 1, 0, 1, 1, 3, 0, 0));
      tbl.push_back(mk(0, 0, 1, 0, 1, 0, 1, 0, 3, 0, 0));
      tbl.push_back(mk(0, 0, 1, 0, 1, 0, 1, 0, 3, 0, 0));
      tbl.push_back(mk(0, 0, 0, 1, 1, 0, 1, 1, 2, 0, 0));
      tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 1, 1, 0, 0));
      tbl.push_back(mk(0, 0, 1, 1, 1, 0, 1, 1, 1, 0, 0));
      tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 1, 0, 0, 0));
      tbl.push_back(mk(0, 0, 1, 0, 1, 0, 1, 1, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 1, 0, 1, 0));
      tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1, 0, 1, 0));
      for (int i = 0; i < tbl.size(); i++) begin
         in0_req_vld  = tbl[i].rv;
         out0_req_rdy = tbl[i].tr;
         out0_ack_vld = tbl[i].av;
         in0_ack_rdy  = tbl[i].ar;
         req_in       = '0;
         req_in.addr  = 32'h200 + 32'(4 * (i + 1));
         ack_in       = '0;
         ack_in.data  = 32'(i);
         tick();
         chk($sformatf("tbl%0d_irdy", i + 1), in0_req_rdy, tbl[i].e_irdy);
         chk($sformatf("tbl%0d_ovld", i + 1), out0_req_vld, tbl[i].e_ovld);
         chk($sformatf("tbl%0d_avld", i + 1), in0_ack_vld, tbl[i].e_avld);
         chk($sformatf("tbl%0d_oardy", i + 1), out0_ack_rdy, tbl[i].e_oardy);
         chk($sformatf("tbl%0d_cnt", i + 1), outst_cnt, tbl[i].e_cnt);
         chk($sformatf("tbl%0d_err", i + 1), outst_err, tbl[i].e_err);
         if (tbl[i].e_src != 0)
            chk($sformatf("tbl%0d_addr", i + 1), o_addr, 32'h200 + 32'(4 * tbl[i].e_src));
      end

      // Back-to-back streaming with immediate acks
      do_reset();
      for (int i = 0; i < 8; i++) begin
         pay[i] = REQ_W'({$urandom(), $urandom(), $urandom()});
         pay[i].addr = 32'h100 + 32'(4 * i);
      end
      acks_seen = 0;
      for (int i = 0; i < 12; i++) begin
         in0_req_vld  = (i < 8);
         req_in       = (i < 8) ? pay[i] : '0;
         out0_req_rdy = 1'b1;
         in0_ack_rdy  = 1'b1;
         out0_ack_vld = out0_req_vld;
         ack_in       = {req_out.opcode, ~req_out.data, req_out.tgt_id, req_out.src_id};
         if (i < 8) chk($sformatf("b2b%0d_irdy", i), in0_req_rdy, 1'b1);
         if (out0_req_vld) begin
            chk($sformatf("b2b%0d_oardy", i), out0_ack_rdy, 1'b1);
            exp_ack.push_back(ack_in);
         end
         tick();
         if (i < 8) begin
            chk($sformatf("b2b%0d_ovld", i), out0_req_vld, 1'b1);
            chk($sformatf("b2b%0d_req", i), req_out, pay[i]);
         end else begin
            chk($sformatf("b2b%0d_ovld", i), out0_req_vld, 1'b0);
         end
         if (in0_ack_vld) begin
            acks_seen++;
            if (exp_ack.size() > 0) chk($sformatf("b2b_ack%0d", acks_seen), ack_out, exp_ack.pop_front());
            else chk("b2b_ack_extra", 1'b1, 1'b0);
         end
      end
      chk("b2b_ack_count", acks_seen, 8);
      chk("b2b_cnt_end", outst_cnt, 0);
      chk("b2b_err_end", outst_err, 1'b0);

      // Random traffic against the model
      do_reset();
      m_rq.delete();
      m_aq.delete();
      m_cnt = 0;
      m_err = 1'b0;
      tgt_pend = 0;
      for (int c = 0; c < 600; c++) model_cycle(1'b0);

      // Fill the request slice, then reset asynchronously mid-cycle
      filled = 1'b0;
      for (int c = 0; c < 30 && !filled; c++) begin
         model_cycle(1'b1);
         filled = out0_req_vld && !in0_req_rdy && (m_cnt < MAXO);
      end
      chk("fill_reached", filled, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_ovld", out0_req_vld, 1'b0);
      chk("arst_avld", in0_ack_vld, 1'b0);
      chk("arst_cnt", outst_cnt, 0);
      chk("arst_irdy", in0_req_rdy, 1'b1);
      chk("arst_oardy", out0_ack_rdy, 1'b1);
      idle_inputs();
      @(negedge clk);
      rst_n = 1'b1;
      out0_req_rdy = 1'b1;
      in0_ack_rdy  = 1'b1;
      tick();
      chk("post_rst_ovld", out0_req_vld, 1'b0);
      chk("post_rst_avld", in0_ack_vld, 1'b0);
      chk("post_rst_cnt", outst_cnt, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
